// File: rtl/i2c_xlate_table_ctrl.sv
// i2c_xlate_table_ctrl: virtual-to-physical I2C address remap table with a sequential one-entry-per-clock lookup.
// Optional saturating lookup-hit counter is enabled by defining XLATE_HIT_CNT_EN.
module i2c_xlate_table_ctrl #(
    parameter int ENTRIES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        cfg_wr,
    input  logic [2:0]  cfg_idx,
    input  logic [6:0]  cfg_virt,
    input  logic [6:0]  cfg_phys,
    input  logic        cfg_valid,
    output logic        cfg_busy,
    output logic [6:0]  cfg_rd_virt,
    output logic [6:0]  cfg_rd_phys,
    output logic        cfg_rd_valid,
    input  logic        lk_req,
    input  logic [6:0]  lk_addr,
    output logic        lk_ack,
    output logic        lk_hit,
    output logic [6:0]  lk_phys,
    output logic [1:0]  state_o,
    input  logic        cnt_clr,
    output logic [15:0] hit_count
);
    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, RESP = 2'd2} state_t;
    state_t      r_state, w_next;
    // Table is sized for the full 3-bit index; slots at or above ENTRIES stay zero.
    logic [6:0]  r_virt  [8];
    logic [6:0]  r_phys  [8];
    logic        r_valid [8];
    logic [6:0]  r_addr, r_lk_phys;
    logic [2:0]  r_idx;
    logic        r_hit, r_ack;
    logic        w_idx_in, w_cfg_ok, w_accept, w_match, w_last;

    assign w_idx_in  = {1'b0, cfg_idx} < 4'(ENTRIES);
    assign w_cfg_ok  = cfg_wr && (r_state == IDLE) && w_idx_in;
    assign w_accept  = (r_state == IDLE) && lk_req;
    assign w_match   = r_valid[r_idx] && (r_virt[r_idx] == r_addr);
    assign w_last    = r_idx == 3'(ENTRIES - 1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = lk_req ? (enable ? SCAN : RESP) : IDLE;
            SCAN:    w_next = (w_match || w_last) ? RESP : SCAN;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr    <= '0;
            r_idx     <= '0;
            r_hit     <= 1'b0;
            r_lk_phys <= '0;
            r_ack     <= 1'b0;
        end else begin
            r_ack <= (w_next == RESP);
            if (w_accept) begin
                r_addr <= lk_addr;
                r_idx  <= '0;
            end else if (r_state == SCAN && !w_match && !w_last) begin
                r_idx <= r_idx + 3'd1;
            end
            if (w_accept && !enable) begin
                r_hit     <= 1'b0;
                r_lk_phys <= lk_addr;
            end else if (r_state == SCAN && w_match) begin
                r_hit     <= 1'b1;
                r_lk_phys <= r_phys[r_idx];
            end else if (r_state == SCAN && w_last) begin
                r_hit     <= 1'b0;
                r_lk_phys <= r_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                r_virt[i]  <= '0;
                r_phys[i]  <= '0;
                r_valid[i] <= 1'b0;
            end
        end else if (w_cfg_ok) begin
            r_virt[cfg_idx]  <= cfg_virt;
            r_phys[cfg_idx]  <= cfg_phys;
            r_valid[cfg_idx] <= cfg_valid;
        end
    end

    assign cfg_busy     = r_state != IDLE;
    assign cfg_rd_virt  = w_idx_in ? r_virt[cfg_idx] : 7'd0;
    assign cfg_rd_phys  = w_idx_in ? r_phys[cfg_idx] : 7'd0;
    assign cfg_rd_valid = w_idx_in && r_valid[cfg_idx];
    assign lk_ack       = r_ack;
    assign lk_hit       = r_hit;
    assign lk_phys      = r_lk_phys;
    assign state_o      = r_state;

`ifdef XLATE_HIT_CNT_EN
    logic [15:0] r_hit_cnt;
    // Clear has priority over a coincident hit; count saturates instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                                   r_hit_cnt <= '0;
        else if (cnt_clr)                                            r_hit_cnt <= '0;
        else if (r_state == RESP && r_hit && r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
    end
    assign hit_count = r_hit_cnt;
`else
    logic w_unused_clr;
    assign w_unused_clr = cnt_clr;
    assign hit_count    = '0;
`endif
endmodule
